// File: rtl/logic_op_pkg.sv
// -----------------------------------------------------------------------------
// logic_op_pkg
// Shared definitions for the logic_op_pipe datapath unit.
//   logic_op_e      : 3-bit operation select (eight bitwise operations)
//   TXN_CNT_W       : width of the optional accepted-transaction counter
//   LOGIC_OP_MAX_W  : widest operand the evaluation helper supports
//   logic_op_eval() : bitwise operation on LOGIC_OP_MAX_W-bit words; callers
//                     zero-extend their W-bit operands and truncate the result
//                     back to W bits. Every operation is bitwise, so no bit of
//                     the result depends on a neighbour and the truncation is
//                     exact.
// -----------------------------------------------------------------------------
package logic_op_pkg;

   typedef enum logic [2:0] {
      OP_XOR    = 3'd0,
      OP_AND    = 3'd1,
      OP_OR     = 3'd2,
      OP_XNOR   = 3'd3,
      OP_NAND   = 3'd4,
      OP_NOR    = 3'd5,
      OP_PASS_A = 3'd6,
      OP_NOT_A  = 3'd7
   } logic_op_e;

   localparam int TXN_CNT_W      = 16;
   localparam int LOGIC_OP_MAX_W = 64;

   typedef logic [LOGIC_OP_MAX_W-1:0] op_word_t;

   function automatic op_word_t logic_op_eval(input logic_op_e op,
                                              input op_word_t  a,
                                              input op_word_t  b);
      op_word_t r;
      case (op)
         OP_XOR:    r = a ^ b;
         OP_AND:    r = a & b;
         OP_OR:     r = a | b;
         OP_XNOR:   r = ~(a ^ b);
         OP_NAND:   r = ~(a & b);
         OP_NOR:    r = ~(a | b);
         OP_PASS_A: r = a;
         OP_NOT_A:  r = ~a;
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_op_stage.sv
// -----------------------------------------------------------------------------
// logic_op_stage
// One pipeline register slice of logic_op_pipe: valid bit, result word, tag
// and zero flag, all loaded together when en_i is high and held otherwise.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   en_i              load enable (global pipeline advance)
//   valid_i/data_i/tag_i/zero_i   slice contents from the previous stage
//   valid_o/data_o/tag_o/zero_o   registered slice contents
// -----------------------------------------------------------------------------
module logic_op_stage #(
   parameter int W     = 4,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             valid_i,
   input  logic [W-1:0]     data_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             zero_i,
   output logic             valid_o,
   output logic [W-1:0]     data_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             zero_o
);

   logic             valid_q, valid_d;
   logic [W-1:0]     data_q,  data_d;
   logic [TAG_W-1:0] tag_q,   tag_d;
   logic             zero_q,  zero_d;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path
      // through this block leaves it unassigned and no latch is inferred.
      valid_d = valid_q;
      data_d  = data_q;
      tag_d   = tag_q;
      zero_d  = zero_q;
      if (en_i) begin
         valid_d = valid_i;
         data_d  = data_i;
         tag_d   = tag_i;
         zero_d  = zero_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the payload is reset as well as the valid bit, because the
         // last slice drives y/out_tag directly and those must read zero in reset.
         valid_q <= 1'b0;
         data_q  <= '0;
         tag_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so all slices sample the previous
         // slice's old value on the same edge and the shift is race-free.
         valid_q <= valid_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         zero_q  <= zero_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign tag_o   = tag_q;
   assign zero_o  = zero_q;

endmodule

// File: rtl/logic_op_pipe.sv
// -----------------------------------------------------------------------------
// logic_op_pipe
// W-bit bitwise logic unit (eight operations) followed by a STAGES-deep
// valid/ready pipeline carrying a sideband tag and a zero flag. The whole
// pipeline advances together whenever the output slot is empty or being
// taken; otherwise every slice (bubbles included) holds.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     input handshake (in_ready = global advance)
//   op, a, b, in_tag        operation select, operands, sideband tag
//   out_valid / out_ready   output handshake
//   y, out_tag, out_zero    registered result, its tag, result==0 flag
//   txn_count               saturating count of accepted beats
//                           (only when LOGIC_OP_PIPE_TXN_COUNT_EN is defined)
// Optional feature macro: LOGIC_OP_PIPE_TXN_COUNT_EN
// Operand width is limited to LOGIC_OP_MAX_W from logic_op_pkg.
// -----------------------------------------------------------------------------
module logic_op_pipe
   import logic_op_pkg::*;
#(
   parameter int W      = 4,
   parameter int STAGES = 2,
   parameter int TAG_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     y,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero
`ifdef LOGIC_OP_PIPE_TXN_COUNT_EN
   ,
   output logic [TXN_CNT_W-1:0] txn_count
`endif
);

   logic         adv;
   logic [W-1:0] result;

   // Index 0 is the combinational entry point; index i is the output of slice i.
   logic [STAGES:0]             stg_valid;
   logic [STAGES:0][W-1:0]      stg_data;
   logic [STAGES:0][TAG_W-1:0]  stg_tag;
   logic [STAGES:0]             stg_zero;

   // The output slot frees up either because it is empty or because it is
   // being consumed this cycle; either way every slice can move forward.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   assign result = W'(logic_op_eval(logic_op_e'(op), op_word_t'(a), op_word_t'(b)));

   assign stg_valid[0] = in_valid;
   assign stg_data[0]  = result;
   assign stg_tag[0]   = in_tag;
   assign stg_zero[0]  = ~|result;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic_op_stage #(
         .W     (W),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .en_i    (adv),
         .valid_i (stg_valid[i]),
         .data_i  (stg_data[i]),
         .tag_i   (stg_tag[i]),
         .zero_i  (stg_zero[i]),
         .valid_o (stg_valid[i+1]),
         .data_o  (stg_data[i+1]),
         .tag_o   (stg_tag[i+1]),
         .zero_o  (stg_zero[i+1])
      );
   end

   assign out_valid = stg_valid[STAGES];
   assign y         = stg_data[STAGES];
   assign out_tag   = stg_tag[STAGES];
   // A bubble may carry a stale zero flag from a don't-care computation.
   assign out_zero  = stg_valid[STAGES] & stg_zero[STAGES];

`ifdef LOGIC_OP_PIPE_TXN_COUNT_EN
   logic [TXN_CNT_W-1:0] txn_cnt_q, txn_cnt_d;

   always_comb begin
      txn_cnt_d = txn_cnt_q;
      if (in_valid && in_ready && (txn_cnt_q != '1)) begin
         txn_cnt_d = txn_cnt_q + TXN_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         txn_cnt_q <= '0;
      end else begin
         txn_cnt_q <= txn_cnt_d;
      end
   end

   assign txn_count = txn_cnt_q;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_op_pipe
// Scoreboard bench for logic_op_pipe (W=4, STAGES=2, TAG_W=8). Each accepted
// input beat pushes its expected result/tag; the monitor pops and compares on
// every output transfer.
// -----------------------------------------------------------------------------
module tb_logic_op_pipe;

   localparam int W      = 4;
   localparam int STAGES = 2;
   localparam int TAG_W  = 8;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     y;
   logic [TAG_W-1:0] out_tag;
   logic             out_zero;
`ifdef LOGIC_OP_PIPE_TXN_COUNT_EN
   logic [15:0]      txn_count;
`endif

   logic_op_pipe #(
      .W      (W),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .out_tag   (out_tag),
      .out_zero  (out_zero)
`ifdef LOGIC_OP_PIPE_TXN_COUNT_EN
      ,
      .txn_count (txn_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]     y;
      logic [TAG_W-1:0] tag;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_pop    = 0;
   int   cyc      = 0;
   bit   lat_chk  = 1'b0;
   bit   rnd_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Independent reference for the eight operations.
   function automatic logic [W-1:0] model_op(input logic [2:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] z);
      case (o)
         3'd0:    return x ^ z;
         3'd1:    return x & z;
         3'd2:    return x | z;
         3'd3:    return ~(x ^ z);
         3'd4:    return ~(x & z);
         3'd5:    return ~(x | z);
         3'd6:    return x;
         default: return ~x;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: compare every output transfer against the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid && out_ready) begin
            check("beat_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               n_pop++;
               check("y", y, e.y);
               check("out_tag", out_tag, e.tag);
               check("out_zero", out_zero, (e.y == '0));
               if (lat_chk) check("latency", cyc - e.cyc, STAGES - 1);
            end
         end else if (!out_valid) begin
            check("zero_idle", out_zero, 0);
         end
      end
   end

   // Called at posedge+1; returns after the beat has been accepted.
   task automatic send(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [TAG_W-1:0] t, input logic [W-1:0] ey, output int stalls);
      logic ok;
      op       = o;
      a        = xa;
      b        = xb;
      in_tag   = t;
      in_valid = 1'b1;
      stalls   = 0;
      ok       = 1'b0;
      while (!ok) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (!ok) begin
            stalls++;
            if (stalls > 200) begin
               check("send_timeout", ok, 1);
               break;
            end
         end
      end
      if (ok) sb.push_back('{ey, t, cyc});
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int             st;
      int             pops_before;
      logic [2:0]     ro;
      logic [W-1:0]   ra, rb, hy;
      logic [TAG_W-1:0] ht;
      logic [W-1:0]   t2 [8];

      t2[0] = 4'h6; t2[1] = 4'h8; t2[2] = 4'hE; t2[3] = 4'h9;
      t2[4] = 4'h7; t2[5] = 4'h1; t2[6] = 4'hC; t2[7] = 4'h3;

      reset     = 1'b0;
      in_valid  = 1'b0;
      op        = '0;
      a         = '0;
      b         = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_out_zero", out_zero, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      // XOR with b=1 over every a, full throughput, latency checked.
      lat_chk = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(3'd0, W'(i), 4'h1, TAG_W'(8'h10 + i), W'(i) ^ 4'h1, st);
         check("t1_in_ready", st, 0);
      end
      idle();
      drain();

      // All eight operations on a=C, b=A.
      for (int i = 0; i < 8; i++) begin
         send(3'(i), 4'hC, 4'hA, TAG_W'(8'h40 + i), t2[i], st);
      end
      idle();
      drain();

      // Zero flag.
      send(3'd0, 4'h5, 4'h5, 8'h50, 4'h0, st);
      send(3'd1, 4'hF, 4'h0, 8'h51, 4'h0, st);
      idle();
      drain();
      lat_chk = 1'b0;

      // Backpressure: 3-cycle stall while a result is presented.
      fork
         begin
            for (int t = 1; t <= 6; t++) begin
               ro = 3'($urandom_range(0, 7));
               ra = W'($urandom_range(0, 15));
               rb = W'($urandom_range(0, 15));
               send(ro, ra, rb, TAG_W'(t), model_op(ro, ra, rb), st);
            end
            idle();
         end
         begin
            int k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (!out_valid && k < 50);
            check("bp_valid_seen", out_valid, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            hy = y;
            ht = out_tag;
            check("bp_stall_valid", out_valid, 1);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("bp_hold_y", y, hy);
               check("bp_hold_tag", out_tag, ht);
               check("bp_in_ready", in_ready, 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Random operations with random output backpressure.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               ro = 3'($urandom_range(0, 7));
               ra = W'($urandom_range(0, 15));
               rb = W'($urandom_range(0, 15));
               send(ro, ra, rb, TAG_W'(8'h80 + i), model_op(ro, ra, rb), st);
            end
            idle();
            rnd_done = 1'b1;
         end
         begin
            for (int k = 0; k < 500 && !rnd_done; k++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset with two beats in flight.
      send(3'd2, 4'h3, 4'h4, 8'h11, 4'h7, st);
      send(3'd1, 4'h6, 4'h3, 8'h12, 4'h2, st);
      idle();
      check("mid_pre_valid", out_valid, 1);
      #1 reset = 1'b0;
      #1;
      check("mid_out_valid", out_valid, 0);
      check("mid_y", y, 0);
      check("mid_out_tag", out_tag, 0);
      check("mid_out_zero", out_zero, 0);
      check("mid_in_ready", in_ready, 1);
      sb.delete();
      pops_before = n_pop;
      @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      send(3'd0, 4'hA, 4'h3, 8'h2A, 4'h9, st);
      idle();
      drain();
      repeat (4) @(posedge clk);
      #1;
      check("mid_single_beat", n_pop - pops_before, 1);

`ifdef LOGIC_OP_PIPE_TXN_COUNT_EN
      reset = 1'b0;
      #1;
      check("cnt_rst", txn_count, 0);
      @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = W'($urandom_range(0, 15));
         rb = W'($urandom_range(0, 15));
         send(ro, ra, rb, TAG_W'(8'hC0 + i), model_op(ro, ra, rb), st);
      end
      idle();
      repeat (5) @(posedge clk);
      #1;
      check("cnt_20", txn_count, 20);
      drain();
      force dut.txn_cnt_q = 16'hFFFE;
      #1 release dut.txn_cnt_q;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         send(3'd6, W'(i), 4'h0, TAG_W'(8'hE0 + i), W'(i), st);
      end
      idle();
      @(posedge clk);
      #1;
      check("cnt_sat", txn_count, 16'hFFFF);
      drain();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
